// File: rtl/window_conv.sv
// Streaming sliding-window sum (unit-coefficient convolution) over a valid/ready
// handshake, with a wrapping or saturating running total of all accepted samples.
module window_conv #(
    parameter int WIDTH     = 4,
    parameter int TAPS      = 3,
    parameter int ACC_WIDTH = 4,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            in_valid,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH+$clog2(TAPS+1)-1:0] out_data,
    output logic [ACC_WIDTH-1:0]            acc,
    output logic                            primed
);

    localparam int OW = WIDTH + $clog2(TAPS + 1);
    localparam int FW = $clog2(TAPS + 1);
    localparam int AW = ((ACC_WIDTH > WIDTH) ? ACC_WIDTH : WIDTH) + 1;
    localparam logic [FW-1:0]        TAPS_C  = FW'(TAPS);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    logic [WIDTH-1:0]     taps [TAPS];
    logic [OW-1:0]        sum;
    logic [OW-1:0]        sum_next;
    logic [FW-1:0]        fill;
    logic [FW-1:0]        fill_next;
    logic [AW-1:0]        acc_sum;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 accept;

    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;

        // The window starts zero-filled, so the dropped tap is 0 until TAPS samples arrive.
        sum_next  = sum + OW'(in_data) - OW'(taps[TAPS-1]);
        fill_next = (fill < TAPS_C) ? fill + 1'b1 : fill;

        acc_sum  = AW'(acc) + AW'(in_data);
        acc_next = acc_sum[ACC_WIDTH-1:0];
        if (SATURATE && (acc_sum > AW'(ACC_MAX)))
            acc_next = ACC_MAX;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, which keeps the tap shift and sum consistent.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++)
                taps[i] <= '0;
            sum       <= '0;
            fill      <= '0;
            acc       <= '0;
            primed    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            // A pending result still drains; a sample offered now is dropped.
            for (int i = 0; i < TAPS; i++)
                taps[i] <= '0;
            sum    <= '0;
            fill   <= '0;
            acc    <= '0;
            primed <= 1'b0;
            if (out_ready)
                out_valid <= 1'b0;
        end else if (accept) begin
            for (int i = TAPS - 1; i > 0; i--)
                taps[i] <= taps[i-1];
            taps[0]   <= in_data;
            sum       <= sum_next;
            fill      <= fill_next;
            primed    <= (fill_next == TAPS_C);
            acc       <= acc_next;
            out_data  <= sum_next;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_conv.sv
// Directed bench for window_conv: wrap and saturate instances share one stimulus
// stream; expected values are hand-computed constants.
module tb_window_conv;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    logic       in_ready0, out_valid0, primed0;
    logic [5:0] out_data0;
    logic [3:0] acc0;
    logic       in_ready1, out_valid1, primed1;
    logic [5:0] out_data1;
    logic [3:0] acc1;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    window_conv #(.WIDTH(4), .TAPS(3), .ACC_WIDTH(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .acc(acc0), .primed(primed0)
    );

    window_conv #(.WIDTH(4), .TAPS(3), .ACC_WIDTH(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .acc(acc1), .primed(primed1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one sample at the falling edge; returns 1 ns after the capturing edge.
    task automatic send(input logic [3:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 'x;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 'x;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] stream   [5] = '{4'd1, 4'd3, 4'd4, 4'd15, 4'd2};
    logic [5:0] exp_sum  [5] = '{6'd1, 6'd4, 6'd8, 6'd22, 6'd21};
    logic [3:0] exp_wrap [5] = '{4'd1, 4'd4, 4'd8, 4'd7, 4'd9};
    logic [3:0] exp_sat  [5] = '{4'd1, 4'd4, 4'd8, 4'd15, 4'd15};
    logic       exp_prim [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid0), 0);
        check("reset out_data",  32'(out_data0), 0);
        check("reset acc",       32'(acc0), 0);
        check("reset primed",    32'(primed1), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset in_ready",  32'(in_ready0), 1);

        // Back-to-back stream, x on in_data between samples.
        for (int i = 0; i < 5; i++) begin
            send(stream[i]);
            check($sformatf("stream[%0d] out_valid", i), 32'(out_valid0), 1);
            check($sformatf("stream[%0d] out_data", i),  32'(out_data0), 32'(exp_sum[i]));
            check($sformatf("stream[%0d] sat out_data", i), 32'(out_data1), 32'(exp_sum[i]));
            check($sformatf("stream[%0d] wrap acc", i),  32'(acc0), 32'(exp_wrap[i]));
            check($sformatf("stream[%0d] sat acc", i),   32'(acc1), 32'(exp_sat[i]));
            check($sformatf("stream[%0d] primed", i),    32'(primed0), 32'(exp_prim[i]));
        end
        idle();
        @(posedge clk);
        #1;
        check("drain out_valid", 32'(out_valid0), 0);
        check("drain out_data held", 32'(out_data0), 21);
        check("drain acc held", 32'(acc1), 15);

        // Backpressure: result 1 is held while sample 3 waits.
        do_reset();
        send(4'd1);
        check("bp first out_data", 32'(out_data0), 1);
        @(negedge clk);
        out_ready = 1'b0;
        in_data   = 4'd3;
        #1;
        check("bp in_ready low", 32'(in_ready0), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold out_data %0d", i), 32'(out_data0), 1);
            check($sformatf("bp hold out_valid %0d", i), 32'(out_valid0), 1);
            check($sformatf("bp hold acc %0d", i), 32'(acc0), 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready0), 1);
        @(posedge clk);
        #1;
        check("bp release out_data", 32'(out_data0), 4);
        check("bp release acc", 32'(acc0), 4);
        idle();
        @(posedge clk);
        #1;
        check("bp no duplicate out_valid", 32'(out_valid0), 0);
        check("bp no duplicate acc", 32'(acc0), 4);

        // Clear discards the concurrent sample but lets the pending result drain.
        do_reset();
        send(4'd1);
        send(4'd3);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd9;
        @(posedge clk);
        #1;
        check("clear acc", 32'(acc0), 0);
        check("clear primed", 32'(primed0), 0);
        check("clear out_data held", 32'(out_data0), 4);
        check("clear out_valid drained", 32'(out_valid0), 0);
        @(negedge clk);
        clear   = 1'b0;
        in_data = 4'd5;
        @(posedge clk);
        #1;
        check("post-clear out_data", 32'(out_data0), 5);
        check("post-clear acc", 32'(acc0), 5);
        check("post-clear primed", 32'(primed0), 0);

        // Reset with a stalled pending result.
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b0;
        #1;
        check("stall in_ready", 32'(in_ready0), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid rst out_valid", 32'(out_valid0), 0);
        check("mid rst acc", 32'(acc0), 0);
        check("mid rst out_data", 32'(out_data0), 0);
        check("mid rst in_ready", 32'(in_ready0), 1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;

        // Maximum-value stress: 45 needs the full 6-bit output.
        send(4'd15);
        check("max[0] out_data", 32'(out_data0), 15);
        send(4'd15);
        check("max[1] out_data", 32'(out_data0), 30);
        check("max[1] wrap acc", 32'(acc0), 14);
        send(4'd15);
        check("max[2] out_data", 32'(out_data0), 45);
        check("max[2] wrap acc", 32'(acc0), 13);
        check("max[2] sat acc", 32'(acc1), 15);
        check("max[2] primed", 32'(primed1), 1);
        idle();
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/window_conv.md
Name: window_conv

Overview:
- Streaming, parametrised successor of the 4-bit accumulate/convert block.
- Accepts unsigned samples over a valid/ready handshake and emits the sliding-window sum of the last TAPS samples (unit-coefficient convolution).
- Keeps a running total of all accepted samples, in wrap or saturate mode.
- Sits between a sample source and downstream logic in the sequential-logic examples; downstream may stall.

Parameters:
- WIDTH, 4: sample width in bits, unsigned.
- TAPS, 3: window length, >= 2.
- ACC_WIDTH, 4: width of the running-total register.
- SATURATE, 0: 0 = running total wraps modulo 2^ACC_WIDTH; 1 = running total clamps at 2^ACC_WIDTH-1.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear of window, fill count and total; keeps handshake state.
- in_valid  in  1  sample offered.
- in_data  in  WIDTH  sample value.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  out_data/acc hold a result.
- out_ready  in  1  downstream takes the result.
- out_data  out  WIDTH+$clog2(TAPS+1)  window sum, exact, never overflows.
- acc  out  ACC_WIDTH  running total of all accepted samples.
- primed  out  1  at least TAPS samples accepted since reset/clear.

Behaviour:
- Reset (rst=1 at posedge): window taps=0, sum=0, fill=0, acc=0, out_data=0, out_valid=0, primed=0. rst overrides clear and any transfer in the same cycle.
- in_ready = !out_valid || out_ready (combinational; single output stage, no skid buffer).
- Accept when in_valid && in_ready at posedge:
  - shift in_data into the window; oldest sample drops out;
  - sum_next = sum + in_data - oldest; oldest is 0 while fill < TAPS;
  - out_data <= sum_next; acc updated; out_valid <= 1.
- Latency: 1 cycle from accept to out_valid/out_data/acc.
- Output handshake:
  - if out_valid && out_ready and no accept in the same cycle, out_valid <= 0;
  - accept together with out_ready gives back-to-back throughput of 1 sample/cycle;
  - while out_valid && !out_ready, out_data and acc hold stable and in_ready=0.
- Running total:
  - SATURATE=0: acc <= (acc + in_data) mod 2^ACC_WIDTH;
  - SATURATE=1: acc <= min(acc + in_data, 2^ACC_WIDTH-1), using an ACC_WIDTH+1 bit internal sum;
  - once saturated, acc stays at max until reset/clear.
- fill: counts accepted samples, saturates at TAPS; primed = (fill == TAPS), registered.
- clear=1 at posedge:
  - taps, sum, fill, acc and primed go to 0;
  - out_valid and out_data are unchanged, so a pending result is still delivered;
  - a sample accepted in the same cycle is discarded (not entered into the window).
- Reset asserted mid-stream: pending result is dropped (out_valid=0) and in_ready=1 the next cycle.
- in_data is ignored when in_valid=0; x on in_data with in_valid=0 must not propagate.

Test Plan:
- Reset then stream 1,3,4,15 (WIDTH=4, TAPS=3, out_ready=1, SATURATE=0) -> out_data 1,4,8,22; acc 1,4,8,7; primed rises with the 3rd result.
- Same stream, SATURATE=1 -> acc 1,4,8,15; further sample 2 -> acc stays 15; out_data 21 (3+4+15 dropped 1, then 4+15+2).
- Backpressure: out_ready=0 after first result (1) while in_valid=1 with 3 -> in_ready=0, out_data stays 1 for 3 cycles; release -> next result 4 one cycle later, no sample lost or duplicated.
- clear asserted after samples 1,3 with in_valid=1, in_data=9 -> 9 discarded, acc=0, primed=0; next sample 5 -> out_data 5, acc 5.
- rst pulsed while out_valid=1 and out_ready=0 -> next cycle out_valid=0, acc=0, out_data=0, in_ready=1.
- Max-value stress: 15,15,15 with TAPS=3 -> out_data 45 (needs 6 bits), no overflow.
